// File: rtl/uart_packet_parser.sv
// uart_packet_parser
// Frames the UART receiver byte stream into 5-byte command packets:
// sync, command, payload high, payload low, XOR checksum. Good frames
// update the command/payload outputs; bad-checksum frames and frames
// stalled mid-packet are dropped and flagged with a one-cycle pulse.

module uart_packet_parser #(
    parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE        = 9600,
    parameter logic [7:0]  SYNC_BYTE        = 8'hA5,
    parameter int unsigned TIMEOUT_BYTES    = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        new_data_in,
    input  logic [7:0]  data_byte_in,
    output logic [7:0]  cmd_out,
    output logic [15:0] payload_out,
    output logic        cmd_valid_out,
    output logic        chk_err_out,
    output logic        timeout_err_out,
    output logic        busy_out
);

    // Line timing derived from the clock and baud rate. A byte on the wire
    // is 10 bit periods (start + 8 data + stop).
    localparam int unsigned BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned TIMEOUT_CYCLES  = TIMEOUT_BYTES * 10 * BAUD_BIT_PERIOD;
    localparam logic [31:0] TIMEOUT_LAST    = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_CMD = 3'd1,
        ST_GET_HI  = 3'd2,
        ST_GET_LO  = 3'd3,
        ST_GET_CHK = 3'd4
    } state_t;

    // Frame checksum: XOR of command and both payload bytes.
    function automatic logic [7:0] frame_checksum(
        input logic [7:0] cmd_byte,
        input logic [7:0] hi_byte,
        input logic [7:0] lo_byte
    );
        return cmd_byte ^ hi_byte ^ lo_byte;
    endfunction

    // State and shadow registers
    state_t      state_r;
    state_t      state_s;
    logic [7:0]  cmd_sh_r;
    logic [7:0]  cmd_sh_s;
    logic [7:0]  hi_sh_r;
    logic [7:0]  hi_sh_s;
    logic [7:0]  lo_sh_r;
    logic [7:0]  lo_sh_s;
    logic [31:0] gap_cnt_r;
    logic [31:0] gap_cnt_s;

    // Output registers and their next values
    logic [7:0]  cmd_r;
    logic [7:0]  cmd_s;
    logic [15:0] payload_r;
    logic [15:0] payload_s;
    logic        cmd_valid_r;
    logic        cmd_valid_s;
    logic        chk_err_r;
    logic        chk_err_s;
    logic        timeout_err_r;
    logic        timeout_err_s;
    logic        busy_r;
    logic        busy_s;

    // Gap limit reached this cycle; a strobe in the same cycle takes priority.
    logic        gap_expired_s;

    // Next-state, shadow capture, gap counting and result pulse generation.
    always_comb begin
        state_s       = state_r;
        cmd_sh_s      = cmd_sh_r;
        hi_sh_s       = hi_sh_r;
        lo_sh_s       = lo_sh_r;
        gap_cnt_s     = gap_cnt_r;
        cmd_s         = cmd_r;
        payload_s     = payload_r;
        cmd_valid_s   = 1'b0;
        chk_err_s     = 1'b0;
        timeout_err_s = 1'b0;
        gap_expired_s = 1'b0;

        // The counter only runs while a frame is in progress and restarts
        // on every received byte.
        if (state_r == ST_IDLE) begin
            gap_cnt_s = 32'd0;
        end else if (new_data_in) begin
            gap_cnt_s = 32'd0;
        end else begin
            gap_cnt_s = gap_cnt_r + 32'd1;
        end

        if ((state_r != ST_IDLE) && !new_data_in && (gap_cnt_r == TIMEOUT_LAST)) begin
            gap_expired_s = 1'b1;
        end else begin
            gap_expired_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                // Only the sync byte opens a frame; anything else is noise.
                if (new_data_in && (data_byte_in == SYNC_BYTE)) begin
                    state_s = ST_GET_CMD;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_GET_CMD: begin
                if (new_data_in) begin
                    cmd_sh_s = data_byte_in;
                    state_s  = ST_GET_HI;
                end else if (gap_expired_s) begin
                    timeout_err_s = 1'b1;
                    gap_cnt_s     = 32'd0;
                    state_s       = ST_IDLE;
                end else begin
                    state_s = ST_GET_CMD;
                end
            end

            ST_GET_HI: begin
                if (new_data_in) begin
                    hi_sh_s = data_byte_in;
                    state_s = ST_GET_LO;
                end else if (gap_expired_s) begin
                    timeout_err_s = 1'b1;
                    gap_cnt_s     = 32'd0;
                    state_s       = ST_IDLE;
                end else begin
                    state_s = ST_GET_HI;
                end
            end

            ST_GET_LO: begin
                if (new_data_in) begin
                    lo_sh_s = data_byte_in;
                    state_s = ST_GET_CHK;
                end else if (gap_expired_s) begin
                    timeout_err_s = 1'b1;
                    gap_cnt_s     = 32'd0;
                    state_s       = ST_IDLE;
                end else begin
                    state_s = ST_GET_LO;
                end
            end

            ST_GET_CHK: begin
                if (new_data_in) begin
                    // Frame is complete either way; only a match publishes it.
                    state_s = ST_IDLE;
                    if (data_byte_in == frame_checksum(cmd_sh_r, hi_sh_r, lo_sh_r)) begin
                        cmd_s       = cmd_sh_r;
                        payload_s   = {hi_sh_r, lo_sh_r};
                        cmd_valid_s = 1'b1;
                    end else begin
                        chk_err_s = 1'b1;
                    end
                end else if (gap_expired_s) begin
                    timeout_err_s = 1'b1;
                    gap_cnt_s     = 32'd0;
                    state_s       = ST_IDLE;
                end else begin
                    state_s = ST_GET_CHK;
                end
            end

            default: begin
                // Unreachable encodings recover to a clean idle state.
                state_s   = ST_IDLE;
                gap_cnt_s = 32'd0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, shadow, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r       <= ST_IDLE;
            cmd_sh_r      <= 8'h00;
            hi_sh_r       <= 8'h00;
            lo_sh_r       <= 8'h00;
            gap_cnt_r     <= 32'd0;
            cmd_r         <= 8'h00;
            payload_r     <= 16'h0000;
            cmd_valid_r   <= 1'b0;
            chk_err_r     <= 1'b0;
            timeout_err_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            cmd_sh_r      <= cmd_sh_s;
            hi_sh_r       <= hi_sh_s;
            lo_sh_r       <= lo_sh_s;
            gap_cnt_r     <= gap_cnt_s;
            cmd_r         <= cmd_s;
            payload_r     <= payload_s;
            cmd_valid_r   <= cmd_valid_s;
            chk_err_r     <= chk_err_s;
            timeout_err_r <= timeout_err_s;
            busy_r        <= busy_s;
        end
    end

    assign cmd_out         = cmd_r;
    assign payload_out     = payload_r;
    assign cmd_valid_out   = cmd_valid_r;
    assign chk_err_out     = chk_err_r;
    assign timeout_err_out = timeout_err_r;
    assign busy_out        = busy_r;

endmodule
